// File: rtl/rcpu_mem_responder.sv
`timescale 1ns/1ps
// RCPU memory-bus slave: a word-addressed RAM window that stalls reads for
// WAIT_STATES cycles and completes writes in the cycle they are presented.
module rcpu_mem_responder #(
   parameter int M           = 16,
   parameter int N           = 32,
   parameter int AW          = 12,
   parameter int BASE        = 0,
   parameter int WAIT_STATES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] memAddr,
   input  logic [M-1:0] memWrite,
   input  logic         memRE,
   input  logic         memWE,
   output logic [M-1:0] memRead,
   output logic         memReady,
   output logic         busErr,
   input  logic         errClr
);

   localparam logic [N-AW-1:0] BASE_TAG = (N-AW)'(BASE);
   localparam logic [3:0]      WS       = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          hit_q, hit_d;
   logic [M-1:0]  rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [M-1:0]  ram_q [2**AW];

   logic [AW-1:0] cur_idx, rd_idx;
   logic          cur_hit, rd_hit, wr_en, load_rd;
   logic [M-1:0]  ram_word;

   assign cur_idx = memAddr[AW-1:0];
   assign cur_hit = (memAddr[N-1:AW] == BASE_TAG);
   assign wr_en   = memWE && cur_hit;

   // In IDLE the read is issued from the live bus; afterwards from the latched address.
   assign rd_idx   = (state_q == S_IDLE) ? cur_idx : idx_q;
   assign rd_hit   = (state_q == S_IDLE) ? cur_hit : hit_q;
   assign ram_word = (wr_en && (cur_idx == rd_idx)) ? memWrite : ram_q[rd_idx];

   // NOTE: the RAM array has no reset branch; contents survive rst and a
   // reset loop over 2**AW words would stop it mapping onto a RAM macro.
   always_ff @(posedge clk) begin
      if (wr_en) ram_q[cur_idx] <= memWrite;
   end

   // NOTE: every sequential assignment is non-blocking so all registers sample
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         hit_q   <= hit_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      hit_d   = hit_q;
      case (state_q)
         S_IDLE: begin
            if (memRE) begin
               idx_d   = cur_idx;
               hit_d   = cur_hit;
               cnt_d   = WS;
               state_d = (WS == 4'd0) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!memRE) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load_rd = (state_d == S_DONE);
      rdata_d = rdata_q;
      if (load_rd) rdata_d = rd_hit ? ram_word : '0;
      // A set in the same cycle as errClr wins.
      err_d = err_q;
      if (errClr) err_d = 1'b0;
      if ((memWE && !cur_hit) || (load_rd && !rd_hit)) err_d = 1'b1;
   end

   assign memRead  = rdata_q;
   assign memReady = (state_q == S_DONE);
   assign busErr   = err_q;

endmodule

// File: tb/tb_rcpu_mem_responder.sv
`timescale 1ns/1ps
// Bench for rcpu_mem_responder: three instances (0, 1, 3 wait states) share one
// CPU-side stimulus and are compared against a transaction-level reference model.
module tb_rcpu_mem_responder;

   localparam int NI = 3;
   int w_of [NI] = '{0, 1, 3};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        re = 1'b0, we = 1'b0, clr = 1'b0;
   logic [15:0] rdata [NI];
   logic        rdy [NI];
   logic        err [NI];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rcpu_mem_responder #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .memAddr(addr), .memWrite(wdata), .memRE(re), .memWE(we),
      .memRead(rdata[0]), .memReady(rdy[0]), .busErr(err[0]), .errClr(clr));
   rcpu_mem_responder #(.WAIT_STATES(1)) dut1 (
      .clk(clk), .rst(rst), .memAddr(addr), .memWrite(wdata), .memRE(re), .memWE(we),
      .memRead(rdata[1]), .memReady(rdy[1]), .busErr(err[1]), .errClr(clr));
   rcpu_mem_responder #(.WAIT_STATES(3)) dut2 (
      .clk(clk), .rst(rst), .memAddr(addr), .memWrite(wdata), .memRE(re), .memWE(we),
      .memRead(rdata[2]), .memReady(rdy[2]), .busErr(err[2]), .errClr(clr));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a read is accepted while idle, completes once memRE has
   // stayed high for W further edges, and the following edge is dead time.
   logic [15:0] mem_m [int];
   int          age [NI];
   bit          cool [NI];
   int          lat_idx [NI];
   bit          lat_hit [NI];
   logic [15:0] m_data [NI];
   bit          m_rdy [NI];
   bit          m_err [NI];
   bit          m_hit, m_done;
   int          m_idx;
   bit          mon_on = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++) begin
            age[i] = -1; cool[i] = 1'b0; m_rdy[i] = 1'b0; m_data[i] = '0; m_err[i] = 1'b0;
         end
      end else begin
         m_hit = (addr[31:12] == 20'h0);
         m_idx = int'(addr[11:0]);
         if (we && m_hit) mem_m[m_idx] = wdata;
         for (int i = 0; i < NI; i++) begin
            m_done = 1'b0;
            if (cool[i]) begin
               cool[i] = 1'b0;
            end else begin
               if (age[i] < 0) begin
                  if (re) begin
                     age[i] = 0; lat_idx[i] = m_idx; lat_hit[i] = m_hit;
                  end
               end else if (!re) begin
                  age[i] = -1;
               end else begin
                  age[i]++;
               end
               if (age[i] == w_of[i]) m_done = 1'b1;
            end
            m_rdy[i] = m_done;
            if (m_done) begin
               m_data[i] = lat_hit[i] ? mem_m[lat_idx[i]] : 16'h0000;
               cool[i]   = 1'b1;
               age[i]    = -1;
            end
            if ((we && !m_hit) || (m_done && !lat_hit[i])) m_err[i] = 1'b1;
            else if (clr) m_err[i] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_on) begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("model ready W=%0d", w_of[i]), 32'(rdy[i]), 32'(m_rdy[i]));
            check($sformatf("model data W=%0d", w_of[i]), 32'(rdata[i]), 32'(m_data[i]));
            check($sformatf("model busErr W=%0d", w_of[i]), 32'(err[i]), 32'(m_err[i]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      re = 1'b0; we = 1'b0; clr = 1'b0;
      repeat (n) step();
   endtask

   task automatic write_word(input logic [31:0] a, input logic [15:0] d);
      addr = a; wdata = d; we = 1'b1; re = 1'b0;
      step();
      we = 1'b0;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [15:0] d;
      logic        re;
      logic        we;
      logic        clr;
      logic        rdy;
      logic [15:0] data;
      logic        err;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exceeded, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      #1 rst = 1'b0;
      mon_on = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset ready W=%0d", w_of[i]), 32'(rdy[i]), 32'd0);
         check($sformatf("reset data W=%0d", w_of[i]), 32'(rdata[i]), 32'd0);
         check($sformatf("reset busErr W=%0d", w_of[i]), 32'(err[i]), 32'd0);
      end
      rst = 1'b1;
      idle(1);

      write_word(32'h0, 16'hAAAA);
      write_word(32'h1, 16'h5555);
      write_word(32'h2, 16'h3333);
      write_word(32'h3, 16'h4444);
      write_word(32'h4, 16'h4B4B);
      for (int j = 5; j < 8; j++) write_word(32'(j), 16'($urandom));
      idle(1);

      // One wait state: ready two cycles after the request edge.
      write_word(32'h10, 16'h1234);
      addr = 32'h10; re = 1'b1;
      step();
      check("w1 ready k+1", 32'(rdy[1]), 32'd0);
      step();
      check("w1 ready k+2", 32'(rdy[1]), 32'd1);
      check("w1 data", 32'(rdata[1]), 32'h1234);
      re = 1'b0;
      step();
      check("w1 ready k+3", 32'(rdy[1]), 32'd0);
      idle(3);

      // Zero wait states: back-to-back reads, window miss, dropped write, errClr.
      tbl[0] = '{32'h0000_0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0};
      tbl[1] = '{32'h0000_0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'hAAAA, 1'b0};
      tbl[2] = '{32'h0000_0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0};
      tbl[3] = '{32'h0000_0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0};
      tbl[4] = '{32'h0001_0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1};
      tbl[5] = '{32'h0001_0000, 16'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
      tbl[6] = '{32'h0000_0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b1};
      tbl[7] = '{32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b0};
      tbl[8] = '{32'h0001_0000, 16'h7777, 1'b0, 1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b1};
      tbl[9] = '{32'h0000_0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b0};
      foreach (tbl[j]) begin
         addr = tbl[j].a; wdata = tbl[j].d; re = tbl[j].re; we = tbl[j].we; clr = tbl[j].clr;
         step();
         check($sformatf("tbl[%0d] ready", j), 32'(rdy[0]), 32'(tbl[j].rdy));
         check($sformatf("tbl[%0d] data", j), 32'(rdata[0]), 32'(tbl[j].data));
         check($sformatf("tbl[%0d] busErr", j), 32'(err[0]), 32'(tbl[j].err));
      end
      idle(3);

      // Three wait states: abort mid-wait, then a clean read.
      addr = 32'h2; re = 1'b1;
      step();
      step();
      check("w3 abort ready k+2", 32'(rdy[2]), 32'd0);
      re = 1'b0;
      for (int j = 0; j < 4; j++) begin
         step();
         check("w3 abort no ready", 32'(rdy[2]), 32'd0);
      end
      addr = 32'h3; re = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         step();
         check($sformatf("w3 ready k+%0d", j), 32'(rdy[2]), 32'(j == 4));
      end
      check("w3 data", 32'(rdata[2]), 32'h4444);
      idle(3);

      // Write and read of the same word in one cycle: read sees new data.
      write_word(32'h20, 16'h0001);
      addr = 32'h20; wdata = 16'hBEEF; we = 1'b1; re = 1'b1;
      step();
      we = 1'b0;
      check("rw W=0 ready", 32'(rdy[0]), 32'd1);
      check("rw W=0 data", 32'(rdata[0]), 32'hBEEF);
      step();
      check("rw W=1 ready", 32'(rdy[1]), 32'd1);
      check("rw W=1 data", 32'(rdata[1]), 32'hBEEF);
      idle(4);

      // Reset in the middle of a wait; RAM must survive.
      write_word(32'h0001_0004, 16'hFFFF);
      check("pre-reset busErr", 32'(err[2]), 32'd1);
      addr = 32'h4; re = 1'b1;
      step();
      #2 rst = 1'b0; re = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("midreset ready W=%0d", w_of[i]), 32'(rdy[i]), 32'd0);
         check($sformatf("midreset data W=%0d", w_of[i]), 32'(rdata[i]), 32'd0);
         check($sformatf("midreset busErr W=%0d", w_of[i]), 32'(err[i]), 32'd0);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      addr = 32'h4; re = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         step();
         check($sformatf("post-reset ready k+%0d", j), 32'(rdy[2]), 32'(j == 4));
      end
      check("post-reset data", 32'(rdata[2]), 32'h4B4B);
      idle(3);

      // Random traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         re    = ($urandom_range(0, 9) < 7);
         addr  = 32'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) addr[31:12] = 20'($urandom_range(1, 20'hFFFFF));
         we    = ($urandom_range(0, 3) == 0);
         wdata = 16'($urandom);
         clr   = ($urandom_range(0, 15) == 0);
         step();
      end
      idle(3);

      mon_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
